pll_lock_sequencer: RTL



---
 rtl/pll_lock_sequencer.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/pll_lock_sequencer.sv
// Supervises CC_PLL lock: clears sticky lock, waits for stable lock, then releases PLL-domain and system resets.
// Latency: lock_s sees pll_lock_in after 2 cycles; registered outputs; no backpressure, lock loss re-sequences.
// Optional: define PLL_SEQ_RELOCK_CNT_EN to add relock_cnt_out, a saturating count of loss-of-lock events.
module pll_lock_sequencer #(
    parameter int LOCK_TIMEOUT  = 100000,
    parameter int LOCK_STABLE   = 1024,
    parameter int GLITCH_FILTER = 4,
    parameter int MAX_RETRY     = 3,
    parameter int RST_HOLD      = 16
) (
    input  logic       clock_in,
    input  logic       rst_n_in,
    input  logic       pll_lock_in,
    output logic       pll_stdy_rst_out,
    output logic       pll_rst_out,
    output logic       sys_rst_n_out,
    output logic [2:0] state_out,
    output logic       fault_out
`ifdef PLL_SEQ_RELOCK_CNT_EN
    ,
    output logic [7:0] relock_cnt_out
`endif
);
    localparam int TMR_W = $clog2(LOCK_TIMEOUT) + 1;
    localparam int STB_W = $clog2(LOCK_STABLE) + 1;
    localparam int GLT_W = $clog2(GLITCH_FILTER) + 1;
    localparam int RTY_W = $clog2(MAX_RETRY) + 1;
    localparam int HLD_W = $clog2(RST_HOLD) + 1;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE - 1);
    localparam logic [GLT_W-1:0] GLT_FULL = GLT_W'(GLITCH_FILTER);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
    localparam logic [HLD_W-1:0] HLD_LAST = HLD_W'(RST_HOLD - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CLEAR     = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_STABLE    = 3'd3,
        ST_RELEASE   = 3'd4,
        ST_RUN       = 3'd5,
        ST_FAULT     = 3'd6
    } state_t;

    state_t           state, state_nxt;
    logic             lock_meta, lock_s;
    logic [TMR_W-1:0] tmr, tmr_nxt;
    logic [STB_W-1:0] stb_cnt, stb_cnt_nxt;
    logic [GLT_W-1:0] glt_cnt, glt_cnt_nxt, glt_inc;
    logic [RTY_W-1:0] retry, retry_nxt, retry_inc;
    logic [HLD_W-1:0] hld_cnt, hld_cnt_nxt;
    logic             clr_cnt, clr_cnt_nxt;
    logic             timeout;
    logic             pll_rst_nxt, sys_rst_n_nxt, stdy_rst_nxt, fault_nxt;

    assign timeout   = (tmr == TMR_LAST);
    assign retry_inc = retry + 1'b1;
    assign glt_inc   = glt_cnt + 1'b1;

    always_ff @(posedge clock_in) begin
        if (!rst_n_in) begin
            lock_meta        <= 1'b0;
            lock_s           <= 1'b0;
            state            <= ST_IDLE;
            tmr              <= '0;
            stb_cnt          <= '0;
            glt_cnt          <= '0;
            retry            <= '0;
            hld_cnt          <= '0;
            clr_cnt          <= 1'b0;
            pll_rst_out      <= 1'b1;
            sys_rst_n_out    <= 1'b0;
            pll_stdy_rst_out <= 1'b0;
            fault_out        <= 1'b0;
        end else begin
            lock_meta        <= pll_lock_in;
            lock_s           <= lock_meta;
            state            <= state_nxt;
            tmr              <= tmr_nxt;
            stb_cnt          <= stb_cnt_nxt;
            glt_cnt          <= glt_cnt_nxt;
            retry            <= retry_nxt;
            hld_cnt          <= hld_cnt_nxt;
            clr_cnt          <= clr_cnt_nxt;
            pll_rst_out      <= pll_rst_nxt;
            sys_rst_n_out    <= sys_rst_n_nxt;
            pll_stdy_rst_out <= stdy_rst_nxt;
            fault_out        <= fault_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        tmr_nxt     = tmr;
        stb_cnt_nxt = stb_cnt;
        glt_cnt_nxt = glt_cnt;
        retry_nxt   = retry;
        hld_cnt_nxt = hld_cnt;
        clr_cnt_nxt = clr_cnt;

        case (state)
            ST_IDLE: begin
                state_nxt   = ST_CLEAR;
                clr_cnt_nxt = 1'b0;
            end
            ST_CLEAR: begin
                if (clr_cnt) begin
                    state_nxt = ST_WAIT_LOCK;
                    tmr_nxt   = '0;
                end else begin
                    clr_cnt_nxt = 1'b1;
                end
            end
            // Timeout wins over lock in both waiting states so the budget is exact.
            ST_WAIT_LOCK, ST_STABLE: begin
                if (timeout) begin
                    retry_nxt   = retry_inc;
                    clr_cnt_nxt = 1'b0;
                    state_nxt   = (retry_inc == RTY_MAX) ? ST_FAULT : ST_CLEAR;
                end else begin
                    tmr_nxt = tmr + 1'b1;
                    if (state == ST_WAIT_LOCK) begin
                        if (lock_s) begin
                            state_nxt   = ST_STABLE;
                            stb_cnt_nxt = '0;
                        end
                    end else if (!lock_s) begin
                        state_nxt = ST_WAIT_LOCK;
                    end else if (stb_cnt == STB_LAST) begin
                        state_nxt   = ST_RELEASE;
                        hld_cnt_nxt = '0;
                    end else begin
                        stb_cnt_nxt = stb_cnt + 1'b1;
                    end
                end
            end
            ST_RELEASE: begin
                if (!lock_s) begin
                    state_nxt   = ST_CLEAR;
                    clr_cnt_nxt = 1'b0;
                end else if (hld_cnt == HLD_LAST) begin
                    state_nxt   = ST_RUN;
                    retry_nxt   = '0;
                    glt_cnt_nxt = '0;
                end else begin
                    hld_cnt_nxt = hld_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                if (lock_s) begin
                    glt_cnt_nxt = '0;
                end else if (glt_inc == GLT_FULL) begin
                    state_nxt   = ST_CLEAR;
                    clr_cnt_nxt = 1'b0;
                    glt_cnt_nxt = '0;
                end else begin
                    glt_cnt_nxt = glt_inc;
                end
            end
            ST_FAULT: begin
                state_nxt = ST_FAULT;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Outputs follow the next state so they update in the same edge as state_out.
        pll_rst_nxt   = 1'b1;
        sys_rst_n_nxt = 1'b0;
        stdy_rst_nxt  = 1'b0;
        fault_nxt     = 1'b0;
        case (state_nxt)
            ST_CLEAR:   stdy_rst_nxt = 1'b1;
            ST_RELEASE: pll_rst_nxt  = 1'b0;
            ST_RUN: begin
                pll_rst_nxt   = 1'b0;
                sys_rst_n_nxt = 1'b1;
            end
            ST_FAULT:   fault_nxt    = 1'b1;
            default:    ;
        endcase
    end

    assign state_out = state;

`ifdef PLL_SEQ_RELOCK_CNT_EN
    logic [7:0] relock_cnt;

    always_ff @(posedge clock_in) begin
        if (!rst_n_in) begin
            relock_cnt <= '0;
        end else if (state == ST_RUN && state_nxt == ST_CLEAR && relock_cnt != 8'hFF) begin
            relock_cnt <= relock_cnt + 8'd1;
        end
    end

    assign relock_cnt_out = relock_cnt;
`else
    // Loss of lock only re-sequences; no event history is kept.
`endif

endmodule
